// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run/stop/single-step/breakpoint controller (optional CPU_RUN_CTRL_BRK_EN)
module cpu_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int ADR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             brk_en,
    input  logic [ADR_W-1:0] brk_adrs,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             brk_hit,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_BRK  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   run_q, step_q;
    logic   run_edge, step_edge;
    logic   issue;
    logic   mask_set;
    logic   match;

    assign run_edge  = run_req & ~run_q;
    assign step_edge = step_req & ~step_q;

`ifdef CPU_RUN_CTRL_BRK_EN
    logic resume_mask;
    logic unused_pc_hi;

    assign unused_pc_hi = ^pc[31:ADR_W];
    assign match        = brk_en && (pc[ADR_W-1:0] == brk_adrs) && !resume_mask;
    assign brk_hit      = (state_q == S_BRK);

    // Mask drops while the resumed instruction's cpu_en is out, i.e. as the CPU leaves the breakpoint PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resume_mask <= 1'b0;
        end else if (mask_set) begin
            resume_mask <= 1'b1;
        end else if (cpu_en) begin
            resume_mask <= 1'b0;
        end
    end
`else
    logic unused_brk;

    assign unused_brk = ^{brk_en, brk_adrs, pc, mask_set};
    assign match      = 1'b0;
    assign brk_hit    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        mask_set = 1'b0;
        case (state_q)
            S_HALT: begin
                if (run_edge) begin
                    state_d = S_RUN;
                end else if (step_edge) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (run_edge) begin
                    state_d = S_HALT;
                end else if (match) begin
                    state_d = S_BRK;
                end else if (tick) begin
                    issue = 1'b1;
                end
            end
            S_STEP: begin
                if (tick) begin
                    issue   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_BRK: begin
                if (run_edge) begin
                    state_d  = S_RUN;
                    mask_set = 1'b1;
                end else if (step_edge) begin
                    state_d  = S_STEP;
                    mask_set = 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_HALT;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            cpu_en    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_req;
            step_q  <= step_req;
            cpu_en  <= issue;
            if (issue && (instr_cnt != {CNT_W{1'b1}})) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule
